// File: rtl/store_pkg.sv
// Shared types and helpers for the byte-serialising store path.
package store_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        DONE  = 2'b10,
        ERROR = 2'b11
    } state_e;

    // Index of the final byte lane for a given store size.
    function automatic logic [1:0] size_to_last(input logic [1:0] size);
        logic [1:0] last;
        case (size)
            SIZE_BYTE: last = 2'd0;
            SIZE_HALF: last = 2'd1;
            SIZE_WORD: last = 2'd3;
            default:   last = 2'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/byte_lane_select.sv
// Picks one little-endian byte lane out of a 32-bit word.
module byte_lane_select (
    input  logic [31:0] word_i,
    input  logic [1:0]  idx_i,
    output logic [7:0]  byte_o
);

    // 4:1 byte mux
    always_comb begin
        byte_o = 8'h00;
        case (idx_i)
            2'd0:    byte_o = word_i[7:0];
            2'd1:    byte_o = word_i[15:8];
            2'd2:    byte_o = word_i[23:16];
            2'd3:    byte_o = word_i[31:24];
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/store_serializer.sv
// Narrows an RV32 SB/SH/SW request into consecutive byte writes on an
// 8-bit memory port, rejecting illegal sizes and misaligned addresses.
module store_serializer
    import store_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [1:0]            req_size,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ready,
    output logic                  done,
    output logic                  error
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [1:0]            idx_q, idx_d;
    logic [1:0]            last_q, last_d;
    logic                  reject_s;
    logic [7:0]            lane_byte_s;

    assign reject_s = (req_size == SIZE_ILL)
                   || ((req_size == SIZE_HALF) && req_addr[0])
                   || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));

    byte_lane_select u_lane (
        .word_i (data_q),
        .idx_i  (idx_q),
        .byte_o (lane_byte_s)
    );

    // State and capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= 32'h0000_0000;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic; captures only in IDLE so later input changes are ignored
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    data_d  = req_data;
                    idx_d   = 2'd0;
                    last_d  = size_to_last(req_size);
                    state_d = reject_s ? ERROR : WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    if (idx_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode purely from registered state and captured data
    always_comb begin
        req_ready = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            IDLE:  req_ready = 1'b1;
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = addr_q + {{(ADDR_WIDTH-2){1'b0}}, idx_q};
                mem_wdata = lane_byte_s;
            end
            DONE:    done  = 1'b1;
            ERROR:   error = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_store_serializer.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_store_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: pending byte writes plus pending pulses
    logic [31:0] wq_addr[$];
    logic [7:0]  wq_data[$];
    bit          m_done = 1'b0;
    bit          m_err  = 1'b0;

    store_serializer #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step();
        int n;
        if (reset) begin
            wq_addr.delete();
            wq_data.delete();
            m_done = 1'b0;
            m_err  = 1'b0;
        end else if (m_done || m_err) begin
            m_done = 1'b0;
            m_err  = 1'b0;
        end else if (wq_addr.size() > 0) begin
            if (mem_ready) begin
                void'(wq_addr.pop_front());
                void'(wq_data.pop_front());
                if (wq_addr.size() == 0) m_done = 1'b1;
            end
        end else if (req_valid) begin
            n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : (req_size == 2'd2) ? 4 : 0;
            if (n == 0 || (req_addr % n) != 0) begin
                m_err = 1'b1;
            end else begin
                for (int i = 0; i < n; i++) begin
                    wq_addr.push_back(req_addr + i);
                    wq_data.push_back(8'((req_data >> (8 * i)) & 32'hFF));
                end
            end
        end
    endfunction

    // Compare DUT outputs against the model every cycle, mid-period
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("req_ready", {31'd0, req_ready},
                {31'd0, (wq_addr.size() == 0) && !m_done && !m_err});
            cmp("mem_we", {31'd0, mem_we}, {31'd0, wq_addr.size() > 0});
            cmp("mem_addr", mem_addr, (wq_addr.size() > 0) ? wq_addr[0] : 32'h0);
            cmp("mem_wdata", {24'd0, mem_wdata}, {24'd0, (wq_data.size() > 0) ? wq_data[0] : 8'h00});
            cmp("done", {31'd0, done}, {31'd0, m_done});
            cmp("error", {31'd0, error}, {31'd0, m_err});
        end
    end

    // One clock: model consumes the inputs seen at this edge, then inputs may change
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
    endtask

    task automatic lit_write(input string name, input logic [31:0] a, input logic [7:0] d);
        cmp({name, "_we"}, {31'd0, mem_we}, 32'd1);
        cmp({name, "_addr"}, mem_addr, a);
        cmp({name, "_data"}, {24'd0, mem_wdata}, {24'd0, d});
    endtask

    initial begin
        logic [31:0] ea[3];
        logic [1:0]  es[3];
        reset = 1'b1;
        mem_ready = 1'b1;
        set_req(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2);
        cyc();
        cyc();
        chk_en = 1'b1;
        cmp("rst_ready", {31'd0, req_ready}, 32'd1);
        cmp("rst_we", {31'd0, mem_we}, 32'd0);
        reset = 1'b0;

        // Word store 0x100 / DEADBEEF
        cyc();
        set_req(1'b0, 32'h0, 32'h0, 2'd0);
        lit_write("w0", 32'h100, 8'hEF); cyc();
        lit_write("w1", 32'h101, 8'hBE); cyc();
        lit_write("w2", 32'h102, 8'hAD); cyc();
        lit_write("w3", 32'h103, 8'hDE); cyc();
        cmp("w_done", {31'd0, done}, 32'd1); cyc();
        cmp("w_ready", {31'd0, req_ready}, 32'd1);

        // Byte store
        set_req(1'b1, 32'h203, 32'h1234_5678, 2'd0); cyc();
        set_req(1'b0, 32'h0, 32'h0, 2'd0);
        lit_write("b0", 32'h203, 8'h78); cyc();
        cmp("b_done", {31'd0, done}, 32'd1); cyc();

        // Halfword store, request held with changing data while busy
        set_req(1'b1, 32'h202, 32'hFFFF_A55A, 2'd1); cyc();
        req_data = 32'h0BAD_0BAD;
        lit_write("h0", 32'h202, 8'h5A); cyc();
        req_data = 32'h1111_2222;
        lit_write("h1", 32'h203, 8'hA5); cyc();
        cmp("h_done", {31'd0, done}, 32'd1);
        set_req(1'b0, 32'h0, 32'h0, 2'd0); cyc();

        // Rejected requests
        ea[0] = 32'h101; es[0] = 2'd1;
        ea[1] = 32'h102; es[1] = 2'd2;
        ea[2] = 32'h100; es[2] = 2'd3;
        for (int k = 0; k < 3; k++) begin
            set_req(1'b1, ea[k], 32'hCAFE_F00D, es[k]); cyc();
            set_req(1'b0, 32'h0, 32'h0, 2'd0);
            cmp("err_pulse", {31'd0, error}, 32'd1);
            cmp("err_we", {31'd0, mem_we}, 32'd0);
            cyc();
            cmp("err_ready", {31'd0, req_ready}, 32'd1);
            cmp("err_clear", {31'd0, error}, 32'd0);
        end

        // Backpressure: stall 3 cycles on byte 2
        set_req(1'b1, 32'h100, 32'h1122_3344, 2'd2); cyc();
        set_req(1'b0, 32'h0, 32'h0, 2'd0);
        cyc(); cyc();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lit_write("stall", 32'h102, 8'h22); cyc();
        end
        mem_ready = 1'b1;
        lit_write("stall_end", 32'h102, 8'h22); cyc();
        lit_write("bp3", 32'h103, 8'h11); cyc();
        cmp("bp_done", {31'd0, done}, 32'd1); cyc();

        // Reset mid-word after two bytes
        set_req(1'b1, 32'h300, 32'hA1B2_C3D4, 2'd2); cyc();
        set_req(1'b0, 32'h0, 32'h0, 2'd0);
        cyc(); cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        cmp("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        cmp("mid_rst_we", {31'd0, mem_we}, 32'd0);
        cmp("mid_rst_done", {31'd0, done}, 32'd0);
        set_req(1'b1, 32'h3FF, 32'h0000_0099, 2'd0); cyc();
        set_req(1'b0, 32'h0, 32'h0, 2'd0);
        lit_write("post_rst", 32'h3FF, 8'h99); cyc();
        cmp("post_rst_done", {31'd0, done}, 32'd1); cyc();

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC | {30'd0, a[1:0]};
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            set_req($urandom_range(0, 2) != 0, a, $urandom, 2'($urandom_range(0, 3)));
            mem_ready = ($urandom_range(0, 9) < 7);
            reset = ($urandom_range(0, 99) == 0);
            cyc();
        end
        reset = 1'b0;
        set_req(1'b0, 32'h0, 32'h0, 2'd0);
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
